// File: rtl/instr_mem_loader.sv
// Loads the instruction memory from a little-endian byte stream: a 32-bit word-count
// header, then that many 32-bit words, written to consecutive addresses from 0.
module instr_mem_loader #(
    parameter int AWIDTH = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              err,
    output logic [AWIDTH:0]   word_count
);

    localparam logic [31:0] CAPACITY = 32'(1) << AWIDTH;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       hdr_q, hdr_d;
    logic [31:0]       word_q, word_d;
    logic [AWIDTH:0]   word_count_q, word_count_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              accept;
    logic [31:0]       hdr_full;
    logic [AWIDTH:0]   wc_inc;

    assign in_ready   = (state_q == HDR) || (state_q == DATA);
    assign accept     = in_valid && in_ready;
    assign hdr_full   = {in_byte, hdr_q[23:0]};
    assign wc_inc     = word_count_q + (AWIDTH+1)'(1);

    assign mem_we     = (state_q == WRITE);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_hold  = (state_q == HDR) || (state_q == DATA) || (state_q == WRITE);
    assign done       = (state_q == DONE);
    assign err        = (state_q == ERR);
    assign word_count = word_count_q;

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        hdr_d        = hdr_q;
        word_d       = word_q;
        word_count_d = word_count_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d      = HDR;
                    byte_idx_d   = 2'd0;
                    hdr_d        = 32'd0;
                    word_count_d = '0;
                end
            end
            HDR: begin
                if (accept) begin
                    hdr_d[{byte_idx_q, 3'b000} +: 8] = in_byte;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Full-width compare so oversized headers cannot alias into range.
                        if (hdr_full == 32'd0) begin
                            state_d = DONE;
                        end else if (hdr_full > CAPACITY) begin
                            state_d = ERR;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    word_d[{byte_idx_q, 3'b000} +: 8] = in_byte;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d     = WRITE;
                        // word_count doubles as the write pointer; it never exceeds count-1 here.
                        mem_addr_d  = word_count_q[AWIDTH-1:0];
                        mem_wdata_d = {in_byte, word_q[23:0]};
                    end
                end
            end
            WRITE: begin
                word_count_d = wc_inc;
                if (32'(wc_inc) == hdr_q) begin
                    state_d = DONE;
                end else begin
                    state_d = DATA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            byte_idx_q   <= 2'd0;
            hdr_q        <= 32'd0;
            word_q       <= 32'd0;
            word_count_q <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            hdr_q        <= hdr_d;
            word_q       <= word_d;
            word_count_q <= word_count_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

endmodule
